// File: rtl/dispense_pkg.sv
// Shared types and constants for the candy dispense sequencer.
package dispense_pkg;

    // Carousel position register width (saturating step count from home).
    localparam int POS_W = 11;

    // dcmotor output bit positions.
    localparam int DC_FAST = 0;
    localparam int DC_SLOW = 1;
    localparam int DC_GATE = 2;

    typedef enum logic [2:0] {
        IDLE,
        SETUP_OUT,
        MOVE_OUT,
        DISPENSE,
        SETUP_RET,
        MOVE_RET,
        FINISH
    } seq_state_t;

    typedef enum logic [1:0] {
        RUN_FAST,
        RUN_SLOW,
        GAP
    } dc_phase_t;

    // Step count from home to a bin; bin 1 sits at home, sel 0 maps to home.
    function automatic logic [POS_W-1:0] bin_target(input logic [2:0] bin_sel,
                                                    input int steps_per_bin);
        int t;
        t = (int'(bin_sel) - 1) * steps_per_bin;
        if (t < 0) begin
            t = 0;
        end
        if (t > (2 ** POS_W) - 1) begin
            t = (2 ** POS_W) - 1;
        end
        return t[POS_W-1:0];
    endfunction

endpackage

// File: rtl/step_pulse_gen.sv
// Free-running stepper pulse generator: while start is held it emits
// STEP_DIV clocks high, STEP_DIV clocks low, and strobes step_done on
// each falling edge. Also registers the direction pin.
module step_pulse_gen #(
    parameter int STEP_DIV = 6000
) (
    input  logic clk,
    input  logic rstn,
    input  logic start,
    input  logic dir_in,
    output logic step,
    output logic step_done,
    output logic dir
);

    localparam int DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

    logic [DIV_W-1:0] div_cnt_reg;
    logic             step_reg;
    logic             done_reg;
    logic             dir_reg;

    // Half-period counter; dropping start parks the output low immediately.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            div_cnt_reg <= '0;
            step_reg    <= 1'b0;
            done_reg    <= 1'b0;
            dir_reg     <= 1'b0;
        end else begin
            dir_reg  <= dir_in;
            done_reg <= 1'b0;
            if (!start) begin
                div_cnt_reg <= '0;
                step_reg    <= 1'b0;
            end else if (div_cnt_reg == '0) begin
                step_reg    <= ~step_reg;
                div_cnt_reg <= DIV_W'(STEP_DIV - 1);
                done_reg    <= step_reg;
            end else begin
                div_cnt_reg <= div_cnt_reg - DIV_W'(1);
            end
        end
    end

    assign step      = step_reg;
    assign step_done = done_reg;
    assign dir       = dir_reg;

endmodule

// File: rtl/dispense_sequencer.sv
// Candy dispense sequencer: on a Pi request, index the carousel out to the
// selected bin, run the auger/gate for the requested units, return home and
// pulse done. SLOW_CYCLES and GAP_CYCLES must be at least 1.
module dispense_sequencer
    import dispense_pkg::*;
#(
    parameter int STEP_DIV      = 6000,
    parameter int STEPS_PER_BIN = 200,
    parameter int DC_ON_CYCLES  = 1200000,
    parameter int SLOW_CYCLES   = 300000,
    parameter int GAP_CYCLES    = 600000
) (
    input  logic       clk_x1,
    input  logic       rstn,
    input  logic [2:0] sel,
    input  logic [1:0] amount,
    input  logic       candyflag,
    output logic       step,
    output logic       dir,
    output logic [2:0] dcmotor,
    output logic       busy,
    output logic       done
);

    localparam int FAST_CYCLES = DC_ON_CYCLES - SLOW_CYCLES;

    logic             sync1_reg, sync2_reg, sync3_reg, edge_reg;
    logic [2:0]       fill_reg;
    seq_state_t       state_reg, state_next;
    dc_phase_t        phase_reg, phase_next;
    logic [31:0]      cnt_reg, cnt_next;
    logic [2:0]       sel_reg, sel_next;
    logic [2:0]       units_reg, units_next;
    logic [POS_W-1:0] pos_reg, pos_next;
    logic [POS_W-1:0] target;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;
    logic [2:0]       dc_reg, dc_next;
    logic             gen_start, dir_next;
    logic             step_w, step_done_w, dir_w;

    assign target = bin_target(sel_reg, STEPS_PER_BIN);

    // Request synchronizer and rising-edge detect; fill_reg masks the edge
    // until the chain holds real pin samples, so a flag held high through
    // reset is not mistaken for a new request.
    always_ff @(posedge clk_x1 or negedge rstn) begin
        if (!rstn) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            sync3_reg <= 1'b0;
            fill_reg  <= '0;
            edge_reg  <= 1'b0;
        end else begin
            sync1_reg <= candyflag;
            sync2_reg <= sync1_reg;
            sync3_reg <= sync2_reg;
            fill_reg  <= {fill_reg[1:0], 1'b1};
            edge_reg  <= sync2_reg & ~sync3_reg & fill_reg[2];
        end
    end

    // Next-state, counters and registered-output values.
    always_comb begin
        state_next = state_reg;
        phase_next = phase_reg;
        cnt_next   = cnt_reg;
        sel_next   = sel_reg;
        units_next = units_reg;
        pos_next   = pos_reg;

        case (state_reg)
            IDLE: begin
                if (edge_reg && (sel != 3'd0)) begin
                    sel_next   = sel;
                    units_next = {1'b0, amount} + 3'd1;
                    state_next = SETUP_OUT;
                end
            end
            SETUP_OUT: begin
                state_next = (pos_reg == target) ? DISPENSE : MOVE_OUT;
            end
            MOVE_OUT: begin
                if (step_done_w) begin
                    if (pos_reg != '1) begin
                        pos_next = pos_reg + POS_W'(1);
                    end
                    if (pos_next >= target) begin
                        state_next = DISPENSE;
                    end
                end
            end
            DISPENSE: begin
                case (phase_reg)
                    RUN_FAST: begin
                        if (cnt_reg == 32'(FAST_CYCLES - 1)) begin
                            phase_next = RUN_SLOW;
                            cnt_next   = '0;
                        end else begin
                            cnt_next = cnt_reg + 32'd1;
                        end
                    end
                    RUN_SLOW: begin
                        if (cnt_reg == 32'(SLOW_CYCLES - 1)) begin
                            phase_next = GAP;
                            cnt_next   = '0;
                        end else begin
                            cnt_next = cnt_reg + 32'd1;
                        end
                    end
                    GAP: begin
                        if (cnt_reg == 32'(GAP_CYCLES - 1)) begin
                            cnt_next = '0;
                            if (units_reg <= 3'd1) begin
                                state_next = SETUP_RET;
                            end else begin
                                units_next = units_reg - 3'd1;
                                phase_next = RUN_FAST;
                            end
                        end else begin
                            cnt_next = cnt_reg + 32'd1;
                        end
                    end
                    default: phase_next = RUN_FAST;
                endcase
            end
            SETUP_RET: begin
                state_next = (pos_reg == '0) ? FINISH : MOVE_RET;
            end
            MOVE_RET: begin
                if (step_done_w) begin
                    if (pos_reg != '0) begin
                        pos_next = pos_reg - POS_W'(1);
                    end
                    if (pos_next == '0) begin
                        state_next = FINISH;
                    end
                end
            end
            FINISH: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        // Every entry into DISPENSE starts the first unit from a clean count.
        if ((state_next == DISPENSE) && (state_reg != DISPENSE)) begin
            phase_next = RUN_FAST;
            cnt_next   = '0;
        end

        // Outputs are derived from the next state so the pins line up with it.
        busy_next = (state_next != IDLE);
        done_next = (state_next == FINISH);
        dc_next   = '0;
        if (state_next == DISPENSE) begin
            dc_next[DC_GATE] = 1'b1;
            dc_next[DC_FAST] = (phase_next == RUN_FAST);
            dc_next[DC_SLOW] = (phase_next == RUN_SLOW);
        end
        gen_start = (state_next == MOVE_OUT) || (state_next == MOVE_RET);
        dir_next  = dir_w;
        if (state_next == SETUP_OUT) begin
            dir_next = 1'b1;
        end else if (state_next == SETUP_RET) begin
            dir_next = 1'b0;
        end
    end

    // Sequencer state, counters and output registers.
    always_ff @(posedge clk_x1 or negedge rstn) begin
        if (!rstn) begin
            state_reg <= IDLE;
            phase_reg <= RUN_FAST;
            cnt_reg   <= '0;
            sel_reg   <= '0;
            units_reg <= '0;
            pos_reg   <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            dc_reg    <= '0;
        end else begin
            state_reg <= state_next;
            phase_reg <= phase_next;
            cnt_reg   <= cnt_next;
            sel_reg   <= sel_next;
            units_reg <= units_next;
            pos_reg   <= pos_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
            dc_reg    <= dc_next;
        end
    end

    step_pulse_gen #(
        .STEP_DIV (STEP_DIV)
    ) u_step_gen (
        .clk       (clk_x1),
        .rstn      (rstn),
        .start     (gen_start),
        .dir_in    (dir_next),
        .step      (step_w),
        .step_done (step_done_w),
        .dir       (dir_w)
    );

    assign step    = step_w;
    assign dir     = dir_w;
    assign dcmotor = dc_reg;
    assign busy    = busy_reg;
    assign done    = done_reg;

endmodule

// File: tb/tb_dispense_sequencer.sv
// Testbench for dispense_sequencer: a queue-based model expands each accepted
// request into its expected per-cycle output trace and one process compares
// every cycle; directed scenarios add literal pulse/duration counts.
module tb_dispense_sequencer;

    localparam int DIV  = 2;
    localparam int SPB  = 4;
    localparam int ON   = 8;
    localparam int SLOW = 2;
    localparam int GAPC = 4;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [2:0] sel = 3'd0;
    logic [1:0] amount = 2'd0;
    logic       candyflag = 1'b0;
    logic       step, dir, busy, done;
    logic [2:0] dcmotor;

    dispense_sequencer #(
        .STEP_DIV      (DIV),
        .STEPS_PER_BIN (SPB),
        .DC_ON_CYCLES  (ON),
        .SLOW_CYCLES   (SLOW),
        .GAP_CYCLES    (GAPC)
    ) dut (
        .clk_x1    (clk),
        .rstn      (rstn),
        .sel       (sel),
        .amount    (amount),
        .candyflag (candyflag),
        .step      (step),
        .dir       (dir),
        .dcmotor   (dcmotor),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       dir;
        logic       dir_care;
        logic       step;
        logic [2:0] dc;
    } exp_t;

    exp_t exp_q[$];
    int   accept_at[$];
    int   cyc = 0;
    logic flag_prev = 1'b0;
    bit   flag_prev_valid = 1'b0;
    bit   last_idle = 1'b1;
    exp_t cur;

    int checks = 0;
    int passes = 0;

    int   step_out = 0, step_ret = 0, dc0_cyc = 0, dc1_cyc = 0, dc2_cyc = 0;
    int   done_cnt = 0, busy_cyc = 0;
    logic step_d = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // n steps: DIV high, DIV low, except the last low lasts one clock before
    // the sequencer moves on (position counts on the falling edge).
    function automatic void push_steps(input int n, input logic d);
        exp_t e;
        e = '0;
        e.busy = 1'b1;
        e.dir = d;
        e.dir_care = 1'b1;
        for (int k = 0; k < n; k++) begin
            e.step = 1'b1;
            repeat (DIV) exp_q.push_back(e);
            e.step = 1'b0;
            repeat ((k == n - 1) ? 1 : DIV) exp_q.push_back(e);
        end
    endfunction

    // Whole expected trace of one accepted request, from the clock after accept.
    function automatic void push_trace(input int s, input int a);
        int   n;
        exp_t e;
        n = (s - 1) * SPB;
        e = '0; e.busy = 1'b1; e.dir = 1'b1; e.dir_care = 1'b1;
        exp_q.push_back(e);
        push_steps(n, 1'b1);
        for (int u = 0; u <= a; u++) begin
            e = '0; e.busy = 1'b1;
            e.dc = 3'b101; repeat (ON - SLOW) exp_q.push_back(e);
            e.dc = 3'b110; repeat (SLOW) exp_q.push_back(e);
            e.dc = 3'b100; repeat (GAPC) exp_q.push_back(e);
        end
        e = '0; e.busy = 1'b1; e.dir_care = 1'b1;
        exp_q.push_back(e);
        push_steps(n, 1'b0);
        e = '0; e.busy = 1'b1; e.done = 1'b1; e.dir_care = 1'b1;
        exp_q.push_back(e);
    endfunction

    // Model on the rising edge, compare and count on the falling edge.
    always @(posedge clk or negedge clk) begin
        if (clk) begin
            if (!rstn) begin
                exp_q.delete();
                accept_at.delete();
                flag_prev_valid = 1'b0;
                last_idle = 1'b1;
            end else begin
                cyc++;
                while (accept_at.size() > 0 && accept_at[0] <= cyc) begin
                    if (accept_at[0] == cyc && last_idle && sel != 3'd0) begin
                        push_trace(int'(sel), int'(amount));
                    end
                    void'(accept_at.pop_front());
                end
                if (flag_prev_valid && candyflag && !flag_prev) begin
                    accept_at.push_back(cyc + 3);
                end
                flag_prev = candyflag;
                flag_prev_valid = 1'b1;
            end
        end else begin
            if (step && !step_d) begin
                if (dir) step_out++; else step_ret++;
            end
            step_d = step;
            if (dcmotor[0]) dc0_cyc++;
            if (dcmotor[1]) dc1_cyc++;
            if (dcmotor[2]) dc2_cyc++;
            if (done) done_cnt++;
            if (busy) busy_cyc++;
            if (rstn) begin
                if (exp_q.size() > 0) begin
                    cur = exp_q.pop_front();
                    last_idle = 1'b0;
                end else begin
                    cur = '0;
                    cur.dir_care = 1'b1;
                    last_idle = 1'b1;
                end
                check("busy", busy, cur.busy);
                check("done", done, cur.done);
                check("step", step, cur.step);
                check("dcmotor", dcmotor, cur.dc);
                if (cur.dir_care) check("dir", dir, cur.dir);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic wait_idle(input int max_cyc, input string tag);
        int quiet;
        int n;
        quiet = 0;
        n = 0;
        while (quiet < 3 && n < max_cyc) begin
            tick(1);
            n++;
            if (exp_q.size() == 0 && accept_at.size() == 0 && busy == 1'b0) quiet++;
            else quiet = 0;
        end
        check(tag, (quiet >= 3) ? 32'd1 : 32'd0, 32'd1);
    endtask

    int s_out, s_ret, s_dc0, s_dc1, s_dc2, s_done, s_busy, lat, n;

    task automatic snap();
        s_out = step_out; s_ret = step_ret; s_dc0 = dc0_cyc; s_dc1 = dc1_cyc;
        s_dc2 = dc2_cyc; s_done = done_cnt; s_busy = busy_cyc;
    endtask

    initial begin
        // 1: reset with the flag already high
        rstn = 1'b0; candyflag = 1'b1;
        tick(3);
        check("rst_step", step, 0);
        check("rst_dir", dir, 0);
        check("rst_dcmotor", dcmotor, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        snap();
        rstn = 1'b1;
        tick(12);
        check("t1_no_busy", busy_cyc - s_busy, 0);
        candyflag = 1'b0;
        tick(3);

        // 2: sel=3, amount=1
        snap();
        sel = 3'd3; amount = 2'd1; candyflag = 1'b1;
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (busy && lat == 0) lat = k;
        end
        check("t2_busy_latency", lat, 4);
        wait_idle(400, "t2_complete");
        check("t2_steps_out", step_out - s_out, 8);
        check("t2_steps_ret", step_ret - s_ret, 8);
        check("t2_fast_cycles", dc0_cyc - s_dc0, 12);
        check("t2_slow_cycles", dc1_cyc - s_dc1, 4);
        check("t2_gate_cycles", dc2_cyc - s_dc2, 24);
        check("t2_done_pulses", done_cnt - s_done, 1);

        // 3: sel=1, amount=0 -> no stepping
        candyflag = 1'b0; tick(3);
        snap();
        sel = 3'd1; amount = 2'd0; candyflag = 1'b1;
        wait_idle(200, "t3_complete");
        check("t3_steps_out", step_out - s_out, 0);
        check("t3_steps_ret", step_ret - s_ret, 0);
        check("t3_fast_cycles", dc0_cyc - s_dc0, 6);
        check("t3_slow_cycles", dc1_cyc - s_dc1, 2);
        check("t3_done_pulses", done_cnt - s_done, 1);

        // 4: sel=0 edge is ignored
        candyflag = 1'b0; tick(3);
        snap();
        sel = 3'd0; amount = 2'd2; candyflag = 1'b1;
        tick(20);
        check("t4_busy_cycles", busy_cyc - s_busy, 0);
        check("t4_gate_cycles", dc2_cyc - s_dc2, 0);
        check("t4_done_pulses", done_cnt - s_done, 0);

        // 5: second edge during MOVE_OUT with sel changed to 7
        candyflag = 1'b0; tick(3);
        snap();
        sel = 3'd3; amount = 2'd0; candyflag = 1'b1;
        n = 0;
        while (step_out - s_out < 2 && n < 100) begin tick(1); n++; end
        check("t5_reached_move", (step_out - s_out >= 2) ? 32'd1 : 32'd0, 32'd1);
        sel = 3'd7; candyflag = 1'b0;
        tick(2);
        candyflag = 1'b1;
        wait_idle(400, "t5_complete");
        check("t5_steps_out", step_out - s_out, 8);
        check("t5_steps_ret", step_ret - s_ret, 8);
        check("t5_fast_cycles", dc0_cyc - s_dc0, 6);
        check("t5_done_pulses", done_cnt - s_done, 1);

        // 6: reset during DISPENSE, then sel=2, amount=3
        candyflag = 1'b0; tick(3);
        sel = 3'd2; amount = 2'd1; candyflag = 1'b1;
        n = 0;
        while (!dcmotor[2] && n < 200) begin tick(1); n++; end
        check("t6_reached_dispense", dcmotor[2], 1);
        rstn = 1'b0;
        #1;
        check("t6_rst_dcmotor", dcmotor, 0);
        check("t6_rst_step", step, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_done", done, 0);
        candyflag = 1'b0;
        tick(3);
        rstn = 1'b1;
        tick(6);
        snap();
        sel = 3'd2; amount = 2'd3; candyflag = 1'b1;
        wait_idle(400, "t6_complete");
        check("t6_steps_out", step_out - s_out, 4);
        check("t6_steps_ret", step_ret - s_ret, 4);
        check("t6_fast_cycles", dc0_cyc - s_dc0, 24);
        check("t6_done_pulses", done_cnt - s_done, 1);

        // Randomized requests with flag chatter and sel changes while busy
        for (int t = 0; t < 10; t++) begin
            candyflag = 1'b0;
            sel = 3'($urandom_range(0, 7));
            amount = 2'($urandom_range(0, 3));
            tick($urandom_range(3, 8));
            candyflag = 1'b1;
            for (int c = 0; c < 60; c++) begin
                tick(1);
                if ($urandom_range(0, 7) == 0) begin
                    candyflag = ~candyflag;
                    sel = 3'($urandom_range(0, 7));
                    amount = 2'($urandom_range(0, 3));
                end
            end
            wait_idle(1500, "rand_complete");
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dispense_sequencer.md
Name: dispense_sequencer

Overview:
- Sequences one candy dispense cycle on the 12 MHz board clock, on a rising edge of `candyflag` from the Raspberry Pi.
- Latches the bin select and amount, drives the stepper to index the carousel to the bin, and runs the DC auger/gate for the requested units.
- Returns the carousel home, then pulses `done`.
- Sits between the Pi-facing IO pins and the motor driver pins inside `project_module`.

Parameters:
- `STEP_DIV`, 6000, clocks per half-period of the step pulse (1 kHz step rate at 12 MHz).
- `STEPS_PER_BIN`, 200, stepper steps between adjacent bins.
- `DC_ON_CYCLES`, 1200000, auger run clocks per unit (100 ms).
- `SLOW_CYCLES`, 300000, final clocks of each unit run on the slow drive; must be < `DC_ON_CYCLES`.
- `GAP_CYCLES`, 600000, idle clocks between units.

Ports:
- `clk_x1`, in, 1, 12 MHz clock from the FTDI/X1 crystal.
- `rstn`, in, 1, asynchronous active-low reset.
- `sel`, in, 3, bin select (Pi teststate); 0 = no bin.
- `amount`, in, 2, unit count minus one (1..4 units).
- `candyflag`, in, 1, dispense request from the Pi; asynchronous, level.
- `step`, out, 1, stepper step pulse.
- `dir`, out, 1, stepper direction; 1 = outward from home, 0 = toward home.
- `dcmotor`, out, 3, bit0 = auger full drive, bit1 = auger slow drive, bit2 = gate open.
- `busy`, out, 1, high from request accept until `done`.
- `done`, out, 1, one-clock pulse at end of sequence.

Behaviour:
- Reset (async, `rstn` = 0): all outputs 0, FSM in IDLE, all counters 0, carousel position register = 0 (home).
- `candyflag` passes through a 2-flop synchronizer, then a rising-edge detect. The accepted edge is seen in IDLE 3 clocks after the pin rises.
- On the accepted edge in IDLE:
  - If `sel` = 0: ignore the edge and stay in IDLE.
  - Otherwise latch `sel` and `amount` into registers. Target = (`sel` − 1) × `STEPS_PER_BIN`. Unit count = `amount` + 1 (3-bit). `busy` goes to 1 on the next clock.
- Edges arriving while `busy` = 1 are dropped, not queued. `sel` and `amount` changes after latch are ignored.
- FSM states and transitions:
  - IDLE → SETUP_OUT on an accepted edge.
  - SETUP_OUT: `dir` = 1 for 1 clock. Go to MOVE_OUT, or straight to DISPENSE if target = 0.
  - MOVE_OUT: issue steps until the position register equals target, then go to DISPENSE.
  - DISPENSE: `dcmotor[2]` = 1 for the whole state. For each unit:
    - `dcmotor[0]` = 1 for `DC_ON_CYCLES` − `SLOW_CYCLES` clocks;
    - then `dcmotor[1]` = 1 for `SLOW_CYCLES` clocks;
    - then both 0 for `GAP_CYCLES` clocks.
    - After the last unit's gap, go to SETUP_RET.
    - `dcmotor[0]` and `dcmotor[1]` are never 1 together.
  - SETUP_RET: `dir` = 0 for 1 clock, then MOVE_RET, or FINISH if position = 0.
  - MOVE_RET: issue steps until position = 0, then FINISH.
  - FINISH: `done` = 1 for 1 clock, `busy` = 0 on the next clock, return to IDLE.
- Step generation:
  - Each step is `step` high for `STEP_DIV` clocks, then low for `STEP_DIV` clocks.
  - The position register updates (+1 out, −1 return) at the falling edge of `step`.
  - `dir` is stable at least 1 clock before the first rising edge and throughout the move.
- Position register is 11 bits and saturates; the target is always ≤ 6 × `STEPS_PER_BIN`.
- Reset mid-sequence: outputs drop to 0 immediately (asynchronous). Position returns to 0 and the carousel is assumed re-homed by the operator.
- All outputs are registered.

Decomposition:
- `dispense_pkg` holds:
  - the state enum (IDLE, SETUP_OUT, MOVE_OUT, DISPENSE, SETUP_RET, MOVE_RET, FINISH);
  - the DC phase enum (RUN_FAST, RUN_SLOW, GAP);
  - the `dcmotor` bit-index constants;
  - the position width constant.
- Sub-module `step_pulse_gen`:
  - Inputs: `start`, `dir_in`, `STEP_DIV` parameter.
  - Outputs: `step`, a one-clock `step_done` strobe at the falling edge.
  - The sequencer counts those strobes.

Test Plan:
(Bench overrides: `STEP_DIV`=2, `STEPS_PER_BIN`=4, `DC_ON_CYCLES`=8, `SLOW_CYCLES`=2, `GAP_CYCLES`=4.)
1. Reset: hold `rstn`=0 with `candyflag`=1 → all outputs 0. Release → no dispense; the flag is already high, so there is no edge.
2. `sel`=3, `amount`=1, raise `candyflag`:
   - `busy` goes high 4 clocks after the pin rises;
   - exactly 8 step pulses with `dir`=1, each 2 clocks high and 2 clocks low;
   - then 2 units: each `dcmotor[0]` for 6 clocks, `dcmotor[1]` for 2, gap 4, with `dcmotor[2]` high throughout;
   - then 8 steps with `dir`=0, one `done` pulse, and `busy` low.
3. `sel`=1, `amount`=0 → zero step pulses in both directions, 1 unit dispensed, then `done`.
4. `sel`=0 with a `candyflag` edge → `busy` stays 0, no motor activity.
5. Second `candyflag` edge during MOVE_OUT, with `sel` changed to 7 → ignored; the original 8-step target completes, and `done` fires only once.
6. Assert `rstn` low during DISPENSE → `dcmotor`, `step`, and `busy` go to 0 within the same time step. After release, `sel`=2 and `amount`=3 gives 4 out-steps, 4 units, and 4 return steps.
